// File: rtl/sdram_wr_arbiter.sv
// rtl/sdram_wr_arbiter.sv - round-robin arbiter sharing the SDRAM write channel between two pixel writers
//
// Purpose: grants the single SDRAM controller write port to either the draw
// path (requester 0) or the auxiliary writer (requester 1), one transaction at
// a time. No new grant is issued while the LCD refresh read is busy or while
// the arbiter is disabled. A watchdog aborts a transaction whose done pulse
// never arrives.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   en, iRd_Busy           new-grant enable / LCD refresh read busy
//   iReq0/iAddr0/iData0    requester 0 level request, address, pixel
//   oDone0                 requester 0 one-cycle completion pulse
//   iReq1/iAddr1/iData1    requester 1 level request, address, pixel
//   oDone1                 requester 1 one-cycle completion pulse
//   oSDRAM_Wr_Req/Addr/Data  registered write request to the SDRAM controller
//   iSDRAM_Wr_Done         one-cycle write-done pulse from the controller
//   oGrant                 one-hot current owner, 00 when idle
//   oErr_Timeout, iClr_Err sticky watchdog flag and its clear
module sdram_wr_arbiter #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              iRd_Busy,
  input  logic              iReq0,
  input  logic [ADDR_W-1:0] iAddr0,
  input  logic [DATA_W-1:0] iData0,
  output logic              oDone0,
  input  logic              iReq1,
  input  logic [ADDR_W-1:0] iAddr1,
  input  logic [DATA_W-1:0] iData1,
  output logic              oDone1,
  output logic              oSDRAM_Wr_Req,
  output logic [ADDR_W-1:0] oSDRAM_Wr_Addr,
  output logic [DATA_W-1:0] oSDRAM_Wr_Data,
  input  logic              iSDRAM_Wr_Done,
  output logic [1:0]        oGrant,
  output logic              oErr_Timeout,
  input  logic              iClr_Err
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    RELEASE   = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic             lastServed;   // 1: requester 1 was served most recently
  logic [CNT_W-1:0] wdCnt;
  logic             grantNow;
  logic             pick1;
  logic             finish;
  logic             timeoutHit;

  // Next-state and control decode
  always_comb begin
    stateNext  = state;
    grantNow   = 1'b0;
    finish     = 1'b0;
    timeoutHit = 1'b0;
    // Requester 1 wins when alone, or on a tie when requester 0 was served last
    pick1      = iReq1 && (!iReq0 || !lastServed);
    case (state)
      IDLE: begin
        if (en && !iRd_Busy && (iReq0 || iReq1)) begin
          grantNow  = 1'b1;
          stateNext = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // A real done on the last watchdog cycle counts as a normal completion
        if (iSDRAM_Wr_Done) begin
          finish    = 1'b1;
          stateNext = RELEASE;
        end else if (wdCnt == CNT_LAST) begin
          finish     = 1'b1;
          timeoutHit = 1'b1;
          stateNext  = RELEASE;
        end
      end
      RELEASE: begin
        // Owner is still dropping its request level; ignore requests here
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oSDRAM_Wr_Req  <= 1'b0;
      oSDRAM_Wr_Addr <= '0;
      oSDRAM_Wr_Data <= '0;
      oGrant         <= 2'b00;
      oDone0         <= 1'b0;
      oDone1         <= 1'b0;
      oErr_Timeout   <= 1'b0;
      lastServed     <= 1'b1;
      wdCnt          <= '0;
    end else begin
      oDone0 <= 1'b0;
      oDone1 <= 1'b0;

      if (grantNow) begin
        oSDRAM_Wr_Addr <= pick1 ? iAddr1 : iAddr0;
        oSDRAM_Wr_Data <= pick1 ? iData1 : iData0;
        oGrant         <= pick1 ? 2'b10 : 2'b01;
        oSDRAM_Wr_Req  <= 1'b1;
        wdCnt          <= '0;
      end else if (state == WAIT_DONE && !finish) begin
        wdCnt <= wdCnt + CNT_W'(1);
      end

      if (finish) begin
        oSDRAM_Wr_Req <= 1'b0;
        oDone0        <= oGrant[0];
        oDone1        <= oGrant[1];
        lastServed    <= oGrant[1];
      end

      if (state == RELEASE) begin
        oGrant <= 2'b00;
      end

      // Setting the flag takes priority over a simultaneous clear
      if (timeoutHit) begin
        oErr_Timeout <= 1'b1;
      end else if (iClr_Err) begin
        oErr_Timeout <= 1'b0;
      end
    end
  end

endmodule
